// File: rtl/msp430_trace_pkg.sv
// ============================================================================
//  Module   : msp430_trace_pkg
//  Brief    : Shared constants and types for the per-core trace collector.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package msp430_trace_pkg;

    localparam logic [31:0] INSN_EXIT   = 32'h15000001;
    localparam logic [31:0] INSN_REPORT = 32'h15000002;
    localparam logic [31:0] INSN_PUTC   = 32'h15000004;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } trace_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msp430_trace_fifo.sv
// ============================================================================
//  Module   : msp430_trace_fifo
//  Brief    : Power-of-two FIFO with zero-latency head output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module msp430_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw:0]    wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]    rd_ptr_q, rd_ptr_d;
    logic             w_push_en;
    logic             w_pop_en;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

    // Fullness is judged before any same-cycle pop.
    assign w_push_en = push_i & ~full_o;
    assign w_pop_en  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q[c_aw-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/msp430_trace_collector.sv
// ============================================================================
//  Module   : msp430_trace_collector
//  Brief    : Decodes special trace instructions into stdout chars, reports
//             and termination for one core.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module msp430_trace_collector
    import msp430_trace_pkg::*;
#(
    parameter int ID         = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trace_valid,
    input  logic [XLEN-1:0] trace_pc,
    input  logic [XLEN-1:0] trace_insn,
    input  logic            trace_wben,
    input  logic [4:0]      trace_wbreg,
    input  logic [XLEN-1:0] trace_wbdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [15:0]     out_id,
    output logic            report_valid,
    output logic [XLEN-1:0] report_data,
    output logic            termination,
    output logic [XLEN-1:0] exit_code,
    output logic            overflow,
    output logic [7:0]      drop_count,
    output logic [31:0]     insn_count,
    output logic [31:0]     cycle_count
);

    localparam int          c_insn_w = (XLEN < 32) ? XLEN : 32;
    localparam logic [15:0] c_id     = 16'(ID);

    state_e          state_q, state_d;
    logic [XLEN-1:0] r3_q, r3_d;
    logic [XLEN-1:0] exit_code_q, exit_code_d;
    logic [XLEN-1:0] report_data_q, report_data_d;
    logic            report_valid_q, report_valid_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic [31:0]     insn_count_q, insn_count_d;
    logic [31:0]     cycle_count_q, cycle_count_d;

    logic [31:0]     w_insn;
    logic            w_run;
    logic            w_beat;
    logic            w_putc;
    logic            w_report;
    logic            w_exit;
    logic            w_r3_wr;
    logic            w_drop;
    logic            w_fifo_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [7:0]      w_fifo_head;
    logic            w_unused_pc;

    assign w_unused_pc = ^trace_pc;
    assign w_insn      = 32'(trace_insn[c_insn_w-1:0]);

    assign w_run    = (state_q == ST_RUN);
    assign w_beat   = trace_valid & w_run;
    assign w_putc   = w_beat & (w_insn == INSN_PUTC);
    assign w_report = w_beat & (w_insn == INSN_REPORT);
    assign w_exit   = w_beat & (w_insn == INSN_EXIT);
    assign w_drop   = w_putc & w_fifo_full;

    // r3 keeps tracking through DRAIN; decoders read only the pre-edge value.
    assign w_r3_wr  = trace_valid & trace_wben & (trace_wbreg == 5'd3) &
                      (state_q != ST_DONE);

    assign w_fifo_pop = ~w_fifo_empty & out_ready;

    msp430_trace_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_putc),
        .push_data_i (r3_q[7:0]),
        .pop_i       (w_fifo_pop),
        .head_o      (w_fifo_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        r3_d           = r3_q;
        exit_code_d    = exit_code_q;
        report_valid_d = w_report;
        report_data_d  = report_data_q;
        overflow_d     = overflow_q | w_drop;
        drop_count_d   = drop_count_q;
        insn_count_d   = insn_count_q;
        cycle_count_d  = cycle_count_q;

        case (state_q)
            ST_RUN:   if (w_exit) state_d = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        if (w_r3_wr) begin
            r3_d = trace_wbdata;
        end
        if (w_exit) begin
            exit_code_d = r3_q;
        end
        if (w_report) begin
            report_data_d = r3_q;
        end
        if (w_drop) begin
            drop_count_d = sat_inc8(drop_count_q);
        end
        if (w_beat) begin
            insn_count_d = insn_count_q + 32'd1;
        end
        // The exit cycle itself is not counted.
        if (w_run && !w_exit) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            r3_q           <= '0;
            exit_code_q    <= '0;
            report_data_q  <= '0;
            report_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            drop_count_q   <= '0;
            insn_count_q   <= '0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            r3_q           <= r3_d;
            exit_code_q    <= exit_code_d;
            report_data_q  <= report_data_d;
            report_valid_q <= report_valid_d;
            overflow_q     <= overflow_d;
            drop_count_q   <= drop_count_d;
            insn_count_q   <= insn_count_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    // Drained is signalled as soon as DRAIN sees an empty FIFO.
    assign termination  = (state_q == ST_DONE) |
                          ((state_q == ST_DRAIN) & w_fifo_empty);
    assign out_valid    = ~w_fifo_empty;
    assign out_data     = w_fifo_head;
    assign out_id       = c_id;
    assign report_valid = report_valid_q;
    assign report_data  = report_data_q;
    assign exit_code    = exit_code_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign insn_count   = insn_count_q;
    assign cycle_count  = cycle_count_q;

endmodule

`default_nettype wire
